// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// Master drives operands and out_ready; slave returns the result.
interface pipelined_add_sub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         carry_in;
    logic         op_sub;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output in_valid, a, b, carry_in, op_sub, sat_en, out_ready,
        input  in_ready, out_valid, c, carry_out, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, carry_in, op_sub, sat_en, out_ready,
        output in_ready, out_valid, c, carry_out, overflow, zero
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined fixed-point add/sub: each stage resolves N/STAGES bits of
// the carry chain; saturation and zero are resolved after the last stage.
module pipelined_add_sub #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_add_sub_if.slave  io
);
    localparam int W = N / STAGES;

    logic         advance;
    logic [N-1:0] b_eff;
    logic         cin_eff;

    // Inputs seen by each stage's slice adder
    logic [N-1:0] st_a   [STAGES];
    logic [N-1:0] st_b   [STAGES];
    logic [N-1:0] st_s   [STAGES];
    logic         st_c   [STAGES];
    logic         st_sat [STAGES];
    logic         st_v   [STAGES];

    // Slice adder results, captured on advance
    logic [W:0]   sl_sum [STAGES];
    logic [N-1:0] nx_s   [STAGES];
    logic         nx_c   [STAGES];

    // Stage registers
    logic [N-1:0] a_q   [STAGES];
    logic [N-1:0] b_q   [STAGES];
    logic [N-1:0] s_q   [STAGES];
    logic         c_q   [STAGES];
    logic         sat_q [STAGES];
    logic         v_q   [STAGES];

    logic [N-1:0] sum;
    logic         a_sign;
    logic         ovf;
    logic [N-1:0] sat_val;
    logic [N-1:0] c_res;

    // Global stall: everything shifts when the output slot can drain
    assign advance     = !v_q[STAGES-1] || io.out_ready;
    assign io.in_ready = advance;

    // Subtract folds into add: a + ~b + ~borrow
    assign b_eff   = io.op_sub ? ~io.b : io.b;
    assign cin_eff = io.op_sub ? ~io.carry_in : io.carry_in;

    // Stage 0 takes the ports; later stages take the previous registers
    always_comb begin
        st_a[0]   = io.a;
        st_b[0]   = b_eff;
        st_s[0]   = '0;
        st_c[0]   = cin_eff;
        st_sat[0] = io.sat_en;
        st_v[0]   = io.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_s[k]   = s_q[k-1];
            st_c[k]   = c_q[k-1];
            st_sat[k] = sat_q[k-1];
            st_v[k]   = v_q[k-1];
        end
    end

    // Each stage adds its own W-bit slice with the carry from below
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sl_sum[k] = {1'b0, st_a[k][k*W +: W]}
                      + {1'b0, st_b[k][k*W +: W]}
                      + {{W{1'b0}}, st_c[k]};
            nx_s[k] = st_s[k];
            nx_s[k][k*W +: W] = sl_sum[k][W-1:0];
            nx_c[k] = sl_sum[k][W];
        end
    end

    // Pipeline registers; valid bits travel with the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
                v_q[k]   <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                s_q[k]   <= nx_s[k];
                c_q[k]   <= nx_c[k];
                sat_q[k] <= st_sat[k];
                v_q[k]   <= st_v[k];
            end
        end
    end

    // Overflow and clamping from the final stage registers
    assign sum     = s_q[STAGES-1];
    assign a_sign  = a_q[STAGES-1][N-1];
    assign ovf     = (a_sign == b_q[STAGES-1][N-1]) && (sum[N-1] != a_sign);
    assign sat_val = a_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    assign c_res   = (sat_q[STAGES-1] && ovf) ? sat_val : sum;

    assign io.c         = c_res;
    assign io.carry_out = c_q[STAGES-1];
    assign io.overflow  = ovf;
    assign io.zero      = v_q[STAGES-1] && (c_res == '0);
    assign io.out_valid = v_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub (N=32, STAGES=4):
// directed table, backpressure, reset mid-flight, random stream.
module tb_pipelined_add_sub;
    localparam int N = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.N(N)) io ();

    pipelined_add_sub #(.N(N), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct packed {
        logic [N-1:0] c;
        logic         co;
        logic         ovf;
        logic         z;
    } res_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        logic         sat;
        res_t         e;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic cin, input logic sub,
                                input logic sat, input logic [N-1:0] c,
                                input logic co, input logic ovf,
                                input logic z);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.sat = sat;
        v.e.c = c; v.e.co = co; v.e.ovf = ovf; v.e.z = z;
        return v;
    endfunction

    function automatic res_t model(input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic cin,
                                   input logic sub, input logic sat);
        logic [N:0]   t;
        logic [N-1:0] be;
        logic         ci;
        logic         ov;
        res_t         r;
        be = sub ? ~b : b;
        ci = sub ? ~cin : cin;
        t  = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, ci};
        ov = (a[N-1] == be[N-1]) && (t[N-1] != a[N-1]);
        if (sat && ov)
            r.c = a[N-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            r.c = t[N-1:0];
        r.co  = t[N];
        r.ovf = ov;
        r.z   = (r.c == '0);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.c = io.c; r.co = io.carry_out; r.ovf = io.overflow; r.z = io.zero;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        io.a = v.a; io.b = v.b; io.carry_in = v.cin;
        io.op_sub = v.sub; io.sat_en = v.sat;
    endtask

    task automatic run_one(input string nm, input vec_t v);
        int lat;
        drive(v);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        lat = 1;
        while (!io.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(S));
        chk({nm, " result"}, 64'(dut_res()), 64'(v.e));
        @(posedge clk); #1;
    endtask

    task automatic stream(input int nops, input bit rnd);
        res_t         expq [$];
        res_t         held;
        res_t         er;
        vec_t         pend;
        logic [N-1:0] corner [6];
        bit           have    = 0;
        bit           stalled = 0;
        int           issued  = 0;
        int           got     = 0;
        int           cyc     = 0;
        int           extra   = 0;
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h8000_0000;
        corner[4] = 32'h0000_0001; corner[5] = 32'h00FF_FFFF;
        while (got < nops && cyc < 3000) begin
            if (rnd) io.out_ready = ($urandom_range(0, 3) != 0);
            else     io.out_ready = !(cyc >= 5 && cyc <= 7);
            if (issued < nops && !have) begin
                if (rnd) begin
                    pend.a = ($urandom_range(0, 2) == 0)
                           ? corner[$urandom_range(0, 5)] : N'($urandom);
                    pend.b = ($urandom_range(0, 2) == 0)
                           ? corner[$urandom_range(0, 5)] : N'($urandom);
                    pend.cin = 1'($urandom_range(0, 1));
                    pend.sub = 1'($urandom_range(0, 1));
                    pend.sat = 1'($urandom_range(0, 1));
                end else begin
                    pend.a   = 32'h7FFF_FFFC + N'(issued);
                    pend.b   = N'(issued * 5);
                    pend.cin = issued[2];
                    pend.sub = issued[0];
                    pend.sat = issued[1];
                end
                have = 1;
            end
            drive(pend);
            io.in_valid = have && (!rnd || $urandom_range(0, 4) != 0);
            #1;
            if (!rnd && cyc >= 5 && cyc <= 7)
                chk("bp in_ready low", 64'(io.in_ready), 64'(0));
            if (stalled) begin
                chk("stall out_valid held", 64'(io.out_valid), 64'(1));
                chk("stall result held", 64'(dut_res()), 64'(held));
            end
            if (io.out_valid && io.out_ready) begin
                if (expq.size() == 0) begin
                    extra++;
                end else begin
                    er = expq.pop_front();
                    chk($sformatf("stream result %0d", got),
                        64'(dut_res()), 64'(er));
                end
                got++;
            end
            stalled = io.out_valid && !io.out_ready;
            held    = dut_res();
            if (io.in_valid && io.in_ready) begin
                expq.push_back(model(pend.a, pend.b, pend.cin,
                                     pend.sub, pend.sat));
                issued++;
                have = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        chk("stream results received", 64'(got), 64'(nops));
        repeat (S + 2) begin
            @(posedge clk); #1;
            if (io.out_valid) extra++;
        end
        chk("stream no extra results", 64'(extra), 64'(0));
    endtask

    task automatic reset_mid_flight();
        int spurious = 0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(vecs[i]);
            io.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        drive(vecs[2]);
        rst_n = 1'b0;
        #1;
        chk("rst mid out_valid", 64'(io.out_valid), 64'(0));
        chk("rst mid in_ready", 64'(io.in_ready), 64'(1));
        chk("rst mid outputs", 64'(dut_res()), 64'(0));
        @(posedge clk); #1;
        rst_n       = 1'b1;
        io.in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (io.out_valid) spurious++;
        end
        chk("rst no results emitted", 64'(spurious), 64'(0));
        run_one("post reset op", vecs[5]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0,
                      32'h0000_0000, 1, 0, 1);
        vecs[1]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 1,
                      32'h7FFF_FFFF, 0, 1, 0);
        vecs[2]  = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 0,
                      32'h8000_0000, 0, 1, 0);
        vecs[3]  = mk(32'h0000_0005, 32'h0000_0007, 1, 1, 0,
                      32'hFFFF_FFFD, 0, 0, 0);
        vecs[4]  = mk(32'h8000_0000, 32'h0000_0001, 0, 1, 1,
                      32'h8000_0000, 1, 1, 0);
        vecs[5]  = mk(32'h0000_0001, 32'h0000_0002, 1, 0, 0,
                      32'h0000_0004, 0, 0, 0);
        vecs[6]  = mk(32'h0000_000A, 32'h0000_000A, 0, 1, 0,
                      32'h0000_0000, 1, 0, 1);
        vecs[7]  = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 1,
                      32'h8000_0000, 1, 1, 0);
        vecs[8]  = mk(32'h8000_0000, 32'h8000_0000, 0, 0, 0,
                      32'h0000_0000, 1, 1, 1);
        vecs[9]  = mk(32'h00FF_FFFF, 32'h0000_0001, 0, 0, 0,
                      32'h0100_0000, 0, 0, 0);
        vecs[10] = mk(32'h0000_0000, 32'h0000_0000, 1, 1, 0,
                      32'hFFFF_FFFF, 0, 0, 0);
        vecs[11] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0,
                      32'hFFFF_FFFF, 1, 0, 0);
        vecs[12] = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 1, 1,
                      32'h7FFF_FFFF, 0, 1, 0);

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        io.a         = '0;
        io.b         = '0;
        io.carry_in  = 1'b0;
        io.op_sub    = 1'b0;
        io.sat_en    = 1'b0;

        #12;
        chk("reset out_valid", 64'(io.out_valid), 64'(0));
        chk("reset in_ready", 64'(io.in_ready), 64'(1));
        chk("reset outputs", 64'(dut_res()), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_one($sformatf("vec %0d", i), vecs[i]);

        stream(8, 1'b0);
        reset_mid_flight();
        stream(300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
